// File: rtl/inv_round_sequencer_if.sv
// ---------------------------------------------------------------------------
// inv_round_sequencer_if
// Handshake and buffer-control bundle between the AES-128 decryption
// round sequencer (master) and the surrounding datapath, key schedule,
// byte source and plaintext sink (slave).
//
//   in_valid / in_ready    ciphertext byte handshake (source -> sequencer)
//   key_req / key_round /  round-key request to the key schedule
//   key_ack
//   buf_wr_en / buf_wr_idx / buf_src_sel   state-buffer write port control
//   buf_rd_idx             state-buffer read index (combinational read)
//   dp_valid               byte at buf_rd_idx enters the round datapath
//   round_num / first_ark / last_round     datapath round and bypass selects
//   out_valid / out_ready  plaintext byte handshake (sequencer -> sink)
//   busy / done            status
// ---------------------------------------------------------------------------
interface inv_round_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic       key_req;
  logic [3:0] key_round;
  logic       key_ack;
  logic       buf_wr_en;
  logic [3:0] buf_wr_idx;
  logic       buf_src_sel;
  logic [3:0] buf_rd_idx;
  logic       dp_valid;
  logic [3:0] round_num;
  logic       first_ark;
  logic       last_round;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  modport master (
    input  in_valid, key_ack, out_ready,
    output in_ready, key_req, key_round, buf_wr_en, buf_wr_idx, buf_src_sel,
           buf_rd_idx, dp_valid, round_num, first_ark, last_round, out_valid,
           busy, done
  );

  modport slave (
    output in_valid, key_ack, out_ready,
    input  in_ready, key_req, key_round, buf_wr_en, buf_wr_idx, buf_src_sel,
           buf_rd_idx, dp_valid, round_num, first_ark, last_round, out_valid,
           busy, done
  );
endinterface

// File: rtl/inv_round_sequencer.sv
// ---------------------------------------------------------------------------
// inv_round_sequencer
// Control FSM for the byte-serial AES-128 decryption core. Loads a 16-byte
// ciphertext block into the shared state buffer, recirculates it NR+1 times
// through the round datapath (one round key fetched per pass), then unloads
// the plaintext. Owns no data: only indices, enables and bypass selects.
//
// Parameters
//   NR      number of AES rounds; passes run round_num = NR .. 0
//   DP_LAT  round-datapath latency, byte-in to byte-out (1..31)
//
// Ports
//   clock   rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     inv_round_sequencer_if.master (handshakes, buffer control,
//           datapath selects, status)
// ---------------------------------------------------------------------------
module inv_round_sequencer #(
  parameter int NR     = 10,
  parameter int DP_LAT = 13
) (
  input logic                   clock,
  input logic                   rst_n,
  inv_round_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KEY,
    S_ISSUE,
    S_DRAIN,
    S_UNLOAD
  } state_t;

  localparam logic [3:0] NR_4 = 4'(NR);

  state_t            state, state_d;
  logic [3:0]        wr_idx, wr_idx_d;
  logic [3:0]        rd_idx, rd_idx_d;
  logic [3:0]        round_num, round_d;
  logic              done_q, done_d;
  logic              dp_vld;
  logic [DP_LAT-1:0] vld_p;
  logic              wb_vld;
  logic              in_round;

  // Stage boundary: dp_valid enters vld_p[0]; vld_p[DP_LAT-1] marks the
  // datapath result returning for write-back. Cleared on reset so that
  // bytes in flight at reset never write the buffer afterwards.
  assign wb_vld = vld_p[DP_LAT-1];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_idx    <= 4'd0;
      rd_idx    <= 4'd0;
      round_num <= 4'd0;
      done_q    <= 1'b0;
      vld_p     <= '0;
    end else begin
      state     <= state_d;
      wr_idx    <= wr_idx_d;
      rd_idx    <= rd_idx_d;
      round_num <= round_d;
      done_q    <= done_d;
      vld_p     <= (vld_p << 1) | DP_LAT'(dp_vld);
    end
  end

  always_comb begin
    state_d         = state;
    wr_idx_d        = wr_idx;
    rd_idx_d        = rd_idx;
    round_d         = round_num;
    done_d          = 1'b0;
    dp_vld          = 1'b0;
    bus.in_ready    = 1'b0;
    bus.key_req     = 1'b0;
    bus.out_valid   = 1'b0;
    bus.buf_rd_idx  = 4'd0;
    // Default write source is the datapath return; LOAD overrides it.
    bus.buf_wr_en   = wb_vld;
    bus.buf_src_sel = wb_vld;

    // Write-backs may overlap ISSUE when DP_LAT < 16, so the write index
    // advances on every returning byte regardless of state.
    if (wb_vld) wr_idx_d = wr_idx + 4'd1;

    case (state)
      S_IDLE: state_d = S_LOAD;

      S_LOAD: begin
        bus.in_ready    = 1'b1;
        bus.buf_wr_en   = bus.in_valid;
        bus.buf_src_sel = 1'b0;
        if (bus.in_valid) begin
          wr_idx_d = wr_idx + 4'd1;
          if (wr_idx == 4'd15) begin
            round_d = NR_4;
            state_d = S_KEY;
          end
        end
      end

      S_KEY: begin
        bus.key_req = 1'b1;
        if (bus.key_ack) state_d = S_ISSUE;
      end

      S_ISSUE: begin
        dp_vld         = 1'b1;
        bus.buf_rd_idx = rd_idx;
        rd_idx_d       = rd_idx + 4'd1;
        if (rd_idx == 4'd15) state_d = S_DRAIN;
      end

      // The 16th write-back always lands here: it trails the last read by
      // at least one cycle.
      S_DRAIN: begin
        if (wb_vld && (wr_idx == 4'd15)) begin
          if (round_num == 4'd0) begin
            rd_idx_d = 4'd0;
            state_d  = S_UNLOAD;
          end else begin
            round_d = round_num - 4'd1;
            state_d = S_KEY;
          end
        end
      end

      S_UNLOAD: begin
        bus.out_valid  = 1'b1;
        bus.buf_rd_idx = rd_idx;
        if (bus.out_ready) begin
          rd_idx_d = rd_idx + 4'd1;
          if (rd_idx == 4'd15) begin
            done_d  = 1'b1;
            state_d = S_LOAD;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign in_round       = (state == S_KEY) || (state == S_ISSUE) || (state == S_DRAIN);
  assign bus.busy       = in_round;
  assign bus.round_num  = round_num;
  assign bus.key_round  = round_num;
  assign bus.first_ark  = in_round && (round_num == NR_4);
  assign bus.last_round = in_round && (round_num == 4'd0);
  assign bus.dp_valid   = dp_vld;
  assign bus.buf_wr_idx = wr_idx;
  assign bus.done       = done_q;

endmodule
